bp_be_instr_encoder: RTL

- Converts field-level instruction commands (format, opcode, funct3/funct7, register addresses, immediate) into 32-bit RV64 instruction words. It is the inverse of the bp_be_instr_s field decode.
- Used by the debug/test injection path to feed synthesized instructions into the backend.
- Supports one macro command, load-immediate (LI). LI expands into a one- or two-instruction LUI/ADDIW sequence.
- Registered output with a valid/ready handshake; full throughput for back-to-back commands.

---
 rtl/bp_be_rv64_pkg.sv | 50 +++++
 rtl/bp_be_instr_format.sv | 38 +++
 rtl/bp_be_instr_encoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bp_be_rv64_pkg.sv
// Shared definitions for the RV64 instruction encoder.
//   - bp_be_encode_op_e    : command format selector (R/I/S/B/U/J, LI macro, reserved)
//   - bp_be_encode_state_e : encoder output state
//   - major opcode constants used when expanding LI
//   - bp_be_li_s           : the half of an LI that is held for the trailing ADDIW
//   - li_hi_f              : upper 20 bits of an LI, rounded for the sign of the low 12
package bp_be_rv64_pkg;

  localparam int rv64_instr_width_gp = 32;

  typedef enum logic [2:0] {
    e_enc_r    = 3'd0,
    e_enc_i    = 3'd1,
    e_enc_s    = 3'd2,
    e_enc_b    = 3'd3,
    e_enc_u    = 3'd4,
    e_enc_j    = 3'd5,
    e_enc_li   = 3'd6,
    e_enc_rsvd = 3'd7
  } bp_be_encode_op_e;

  typedef enum logic [1:0] {
    e_state_idle   = 2'd0,
    e_state_out    = 2'd1,
    e_state_out_hi = 2'd2
  } bp_be_encode_state_e;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;

  // Fields needed to build the ADDIW that completes a two-instruction LI.
  typedef struct packed {
    logic [4:0]  rd;
    logic [11:0] lo;
  } bp_be_li_s;

  // ADDI/ADDIW sign-extend their 12-bit immediate, so the upper part is
  // pre-incremented whenever bit 11 of the low part is set.
  function automatic logic [19:0] li_hi_f(input logic [31:0] imm);
    logic [31:0] rounded;
    rounded = imm + 32'h0000_0800;
    return rounded[31:12];
  endfunction

endpackage

// File: rtl/bp_be_instr_format.sv
// Combinational packer: places opcode, funct fields, register addresses and
// immediate into a 32-bit RV64 instruction word for the selected format.
// Ports:
//   op      in  format selector (LI and reserved produce zero)
//   opcode  in  7-bit major opcode
//   funct3  in  3-bit funct3
//   funct7  in  7-bit funct7 (R only)
//   rd/rs1/rs2 in 5-bit register addresses
//   imm     in  32-bit immediate (byte offset for B/J, upper bits for U)
//   instr   out packed instruction word
module bp_be_instr_format
  import bp_be_rv64_pkg::*;
(
  input  bp_be_encode_op_e op,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic [31:0]      instr
);

  always_comb begin
    instr = '0;
    case (op)
      e_enc_r: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      e_enc_i: instr = {imm[11:0], rs1, funct3, rd, opcode};
      e_enc_s: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      e_enc_b: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      e_enc_u: instr = {imm[31:12], rd, opcode};
      e_enc_j: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: instr = '0;
    endcase
  end

endmodule

// File: rtl/bp_be_instr_encoder.sv
// Field-level command to RV64 instruction encoder with a registered,
// valid/ready output. The LI macro expands into ADDI, LUI, or LUI+ADDIW.
// Ports:
//   clk_i, reset_i           clock, asynchronous active-high reset
//   cmd_v_i / cmd_ready_o    command handshake (ready is combinational from instr_ready_i)
//   cmd_op_i                 bp_be_encode_op_e selector
//   cmd_opcode_i, cmd_funct3_i, cmd_funct7_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i, cmd_imm_i
//                            instruction fields
//   instr_v_o / instr_ready_i output handshake
//   instr_o                  encoded instruction
//   instr_last_o             final instruction of the current command
//   illegal_o                one-cycle pulse after a reserved op is accepted
module bp_be_instr_encoder
  import bp_be_rv64_pkg::*;
#(
  parameter int instr_width_p = rv64_instr_width_gp,
  parameter int imm_width_p   = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cmd_v_i,
  output logic                     cmd_ready_o,
  input  logic [2:0]               cmd_op_i,
  input  logic [6:0]               cmd_opcode_i,
  input  logic [2:0]               cmd_funct3_i,
  input  logic [6:0]               cmd_funct7_i,
  input  logic [4:0]               cmd_rd_i,
  input  logic [4:0]               cmd_rs1_i,
  input  logic [4:0]               cmd_rs2_i,
  input  logic [imm_width_p-1:0]   cmd_imm_i,
  output logic                     instr_v_o,
  input  logic                     instr_ready_i,
  output logic [instr_width_p-1:0] instr_o,
  output logic                     instr_last_o,
  output logic                     illegal_o
);

  bp_be_encode_state_e state, state_next;
  logic [instr_width_p-1:0] instr_reg, instr_next;
  bp_be_li_s li_reg, li_next;
  logic illegal_reg, illegal_next;

  bp_be_encode_op_e op;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic        li_pair;
  logic        accept;

  bp_be_encode_op_e fmt_op;
  logic [6:0]  fmt_opcode;
  logic [2:0]  fmt_funct3;
  logic [4:0]  fmt_rs1;
  logic [31:0] fmt_imm;
  logic [31:0] fmt_instr;

  assign op      = bp_be_encode_op_e'(cmd_op_i);
  assign li_hi   = li_hi_f(cmd_imm_i);
  assign li_lo   = cmd_imm_i[11:0];
  assign li_pair = (li_hi != 20'd0) && (li_lo != 12'd0);

  assign cmd_ready_o = (state == e_state_idle) | ((state == e_state_out) & instr_ready_i);
  assign accept      = cmd_v_i & cmd_ready_o;

  // LI reuses the formatter by rewriting the command into the first
  // instruction of its expansion: ADDI rd,x0,lo when no upper part is
  // needed, otherwise LUI rd,hi.
  always_comb begin
    fmt_op     = op;
    fmt_opcode = cmd_opcode_i;
    fmt_funct3 = cmd_funct3_i;
    fmt_rs1    = cmd_rs1_i;
    fmt_imm    = cmd_imm_i;
    if (op == e_enc_li) begin
      if (li_hi == 20'd0) begin
        fmt_op     = e_enc_i;
        fmt_opcode = OP_IMM;
        fmt_funct3 = 3'b000;
        fmt_rs1    = 5'd0;
        fmt_imm    = {{20{li_lo[11]}}, li_lo};
      end else begin
        fmt_op     = e_enc_u;
        fmt_opcode = LUI;
        fmt_imm    = {li_hi, 12'd0};
      end
    end
  end

  bp_be_instr_format format (
    .op     (fmt_op),
    .opcode (fmt_opcode),
    .funct3 (fmt_funct3),
    .funct7 (cmd_funct7_i),
    .rd     (cmd_rd_i),
    .rs1    (fmt_rs1),
    .rs2    (cmd_rs2_i),
    .imm    (fmt_imm),
    .instr  (fmt_instr)
  );

  always_comb begin
    state_next   = state;
    instr_next   = instr_reg;
    li_next      = li_reg;
    illegal_next = accept & (op == e_enc_rsvd);

    case (state)
      e_state_out_hi: begin
        if (instr_ready_i) begin
          state_next = e_state_out;
          instr_next = {li_reg.lo, li_reg.rd, 3'b000, li_reg.rd, OP_IMM32};
        end
      end
      e_state_out: begin
        if (instr_ready_i) begin
          state_next = e_state_idle;
        end
      end
      default: begin
      end
    endcase

    // Acceptance only happens when the output slot is free or being
    // drained this cycle, so the new command overrides the drain path.
    if (accept) begin
      if (op == e_enc_rsvd) begin
        state_next = e_state_idle;
      end else begin
        instr_next = fmt_instr;
        li_next    = '{rd: cmd_rd_i, lo: li_lo};
        state_next = ((op == e_enc_li) && li_pair) ? e_state_out_hi : e_state_out;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= e_state_idle;
      instr_reg   <= '0;
      li_reg      <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state       <= state_next;
      instr_reg   <= instr_next;
      li_reg      <= li_next;
      illegal_reg <= illegal_next;
    end
  end

  assign instr_v_o    = (state != e_state_idle);
  assign instr_last_o = (state == e_state_out);
  assign instr_o      = instr_reg;
  assign illegal_o    = illegal_reg;

endmodule
